// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: EX-stage ALU with zero-latency ops plus a sequential radix-2 MULT/DIV feeding HI/LO.
// Define MULDIV_SIGNED_EN for two's-complement MULT/DIV; otherwise MULTU/DIVU semantics.
module alu_muldiv_seq #(
    parameter int               WIDTH    = 32,
    parameter int               SHAMT_W  = 5,
    parameter logic [WIDTH-1:0] MEM_BASE = WIDTH'(32'h1001_0000)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Start,
    input  logic [3:0]         ALUOperation,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic [WIDTH-1:0]   ALUResult,
    output logic               Zero,
    output logic               Busy,
    output logic               Done
);
`ifdef MULDIV_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_NOR = 4'b0010, OP_ADD = 4'b0011,
                           OP_SUB = 4'b0100, OP_MULT = 4'b0101, OP_DIV = 4'b0110, OP_MFHI = 4'b0111,
                           OP_SLL = 4'b1000, OP_SRL = 4'b1001, OP_MEM = 4'b1010, OP_JR = 4'b1011,
                           OP_BEQ = 4'b1100, OP_MFLO = 4'b1101, OP_LUI = 4'b1110;

    // State bits double as the registered Busy/Done flags.
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               div_q, div_d, sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0]   a_q, a_d, opnd_q, opnd_d, sh_q, sh_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   mag_a, mag_b, mem_sum, step_sh;
    logic [WIDTH:0]     mul_sum, div_rem, step_acc;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;

    assign mem_sum = A + B - MEM_BASE;

    always_comb begin
        case (ALUOperation)
            OP_AND:  ALUResult = A & B;
            OP_OR:   ALUResult = A | B;
            OP_NOR:  ALUResult = ~(A | B);
            OP_ADD:  ALUResult = A + B;
            OP_SUB:  ALUResult = A - B;
            OP_BEQ:  ALUResult = A - B;
            OP_SLL:  ALUResult = B << Shamt;
            OP_SRL:  ALUResult = B >> Shamt;
            OP_LUI:  ALUResult = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_MEM:  ALUResult = mem_sum >> 2;
            OP_JR:   ALUResult = A;
            OP_MFHI: ALUResult = hi_q;
            OP_MFLO: ALUResult = lo_q;
            default: ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == '0);
    assign Busy = state_q[0];
    assign Done = state_q[1];

    // Iteration works on magnitudes; signs are reapplied when HI/LO are written.
    assign mag_a    = (SGN_EN && A[WIDTH-1]) ? -A : A;
    assign mag_b    = (SGN_EN && B[WIDTH-1]) ? -B : B;
    assign mul_sum  = sh_q[0] ? acc_q + {1'b0, opnd_q} : acc_q;
    assign div_rem  = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
    assign div_ge   = div_rem >= {1'b0, opnd_q};
    assign step_acc = div_q ? (div_ge ? div_rem - {1'b0, opnd_q} : div_rem) : {1'b0, mul_sum[WIDTH:1]};
    assign step_sh  = div_q ? {sh_q[WIDTH-2:0], div_ge} : {mul_sum[0], sh_q[WIDTH-1:1]};
    assign prod     = (sa_q ^ sb_q) ? -{step_acc[WIDTH-1:0], step_sh} : {step_acc[WIDTH-1:0], step_sh};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        a_d     = a_q;
        opnd_d  = opnd_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (Start && (ALUOperation == OP_MULT || ALUOperation == OP_DIV)) begin
                state_d = RUN;
                cnt_d   = SHAMT_W'(WIDTH - 1);
                div_d   = (ALUOperation == OP_DIV);
                sa_d    = SGN_EN && A[WIDTH-1];
                sb_d    = SGN_EN && B[WIDTH-1];
                a_d     = A;
                opnd_d  = (ALUOperation == OP_DIV) ? mag_b : mag_a;
                sh_d    = (ALUOperation == OP_DIV) ? mag_a : mag_b;
                acc_d   = '0;
            end
            RUN: begin
                acc_d = step_acc;
                sh_d  = step_sh;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    hi_d = div_q ? ((opnd_q == '0) ? a_q : (sa_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0]))
                                 : prod[2*WIDTH-1:WIDTH];
                    lo_d = div_q ? ((opnd_q == '0) ? '1 : ((sa_q ^ sb_q) ? -step_sh : step_sh))
                                 : prod[WIDTH-1:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            a_q     <= '0;
            opnd_q  <= '0;
            sh_q    <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            a_q     <= a_d;
            opnd_q  <= opnd_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: randomized scoreboard bench for alu_muldiv_seq (WIDTH=32 main instance, WIDTH=16 side instance).
module tb_alu_muldiv_seq;
    localparam int W = 32;

    logic         clk = 1'b0, reset = 1'b0, Start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] A = '0, B = '0;
    logic [4:0]   Shamt = '0;
    logic [W-1:0] ALUResult;
    logic         Zero, Busy, Done;

    logic         s_start = 1'b0;
    logic [3:0]   s_op = 4'd0;
    logic [15:0]  s_a = '0, s_b = '0, s_res;
    logic         s_zero, s_busy, s_done;

    int           tests = 0, fails = 0, cyc = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi, p_lo;

    typedef struct {string name; logic [W-1:0] res;} cexp_t;
    cexp_t cq[$];
    int    le_q[$];

    alu_muldiv_seq dut (
        .clk(clk), .reset(reset), .Start(Start), .ALUOperation(op), .A(A), .B(B), .Shamt(Shamt),
        .ALUResult(ALUResult), .Zero(Zero), .Busy(Busy), .Done(Done)
    );

    alu_muldiv_seq #(.WIDTH(16), .SHAMT_W(4), .MEM_BASE(16'h0000)) dut16 (
        .clk(clk), .reset(reset), .Start(s_start), .ALUOperation(s_op), .A(s_a), .B(s_b), .Shamt(4'd0),
        .ALUResult(s_res), .Zero(s_zero), .Busy(s_busy), .Done(s_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Monitor: drains expected combinational results and tracks Busy/Done against the launch schedule.
    always @(negedge clk) begin
        logic eb, ed;
        while (cq.size() > 0) begin
            cexp_t e;
            e = cq.pop_front();
            chk(e.name, ALUResult, e.res);
            chk({e.name, ".zero"}, W'(Zero), W'(e.res == '0));
        end
        eb = 1'b0;
        ed = 1'b0;
        if (le_q.size() > 0) begin
            eb = (cyc >= le_q[0]) && (cyc < le_q[0] + W);
            ed = (cyc == le_q[0] + W);
        end
        chk("busy", W'(Busy), W'(eb));
        chk("done", W'(Done), W'(ed));
        if (ed) le_q.delete(0);
    end

    function automatic logic [W-1:0] cm(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [4:0] s);
        case (o)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return ~(a | b);
            4'b0011: return a + b;
            4'b0100: return a - b;
            4'b1100: return a - b;
            4'b1000: return b << s;
            4'b1001: return b >> s;
            4'b1110: return {b[15:0], 16'h0000};
            4'b1010: return (a + b - 32'h1001_0000) >> 2;
            4'b1011: return a;
            4'b0111: return m_hi;
            4'b1101: return m_lo;
            default: return '0;
        endcase
    endfunction

    task automatic md_model(input logic dv, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] hi, output logic [W-1:0] lo);
`ifdef MULDIV_SIGNED_EN
        longint p;
        int qa, qb;
        qa = a;
        qb = b;
        p = longint'(qa) * longint'(qb);
        if (!dv) {hi, lo} = p;
        else if (b == '0) begin lo = '1; hi = a; end
        else if (a == 32'h8000_0000 && b == '1) begin lo = a; hi = '0; end
        else begin lo = qa / qb; hi = qa % qb; end
`else
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        if (!dv) {hi, lo} = p;
        else if (b == '0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cchk(input string n, input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] s, input logic st);
        op = o; A = a; B = b; Shamt = s; Start = st;
        cq.push_back('{name: n, res: cm(o, a, b, s)});
        step();
    endtask

    // Only used while an operation is in flight, so a random Start never launches anything.
    task automatic rand_comb();
        logic [3:0] ops [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hC, 4'hE, 4'hA, 4'hB, 4'h5, 4'h6, 4'hF};
        logic [3:0] o;
        o = ops[$urandom_range(0, 13)];
        cchk($sformatf("run_op%0h", o), o, $urandom, $urandom, 5'($urandom), 1'($urandom));
    endtask

    task automatic launch(input logic dv, input logic [W-1:0] a, input logic [W-1:0] b);
        op = dv ? 4'b0110 : 4'b0101; A = a; B = b; Shamt = '0; Start = 1'b1;
        md_model(dv, a, b, p_hi, p_lo);
        le_q.push_back(cyc + 1);
        step();
        Start = 1'b0;
    endtask

    task automatic muldiv(input string n, input logic dv, input logic [W-1:0] a, input logic [W-1:0] b);
        launch(dv, a, b);
        cchk({n, ".old_hi"}, 4'b0111, '0, '0, '0, 1'b0);
        cchk({n, ".restart"}, dv ? 4'b0110 : 4'b0101, $urandom, $urandom, '0, 1'b1);
        for (int i = 0; i < 3 * W && le_q.size() > 0; i++) rand_comb();
        if (le_q.size() > 0) begin
            chk({n, ".done_timeout"}, W'(le_q.size()), '0);
            le_q.delete();
        end
        m_hi = p_hi;
        m_lo = p_lo;
        cchk({n, ".hi"}, 4'b0111, '0, '0, '0, 1'b0);
        cchk({n, ".lo"}, 4'b1101, '0, '0, '0, 1'b0);
    endtask

    initial begin
        int n;
        #1 reset = 1'b1;
        step();
        cchk("rst_mfhi", 4'b0111, '0, '0, '0, 1'b0);
        cchk("rst_mflo", 4'b1101, '0, '0, '0, 1'b0);
        reset = 1'b0;

        cchk("add_zero", 4'b0011, 32'd7, 32'hFFFF_FFF9, '0, 1'b0);
        cchk("sll31", 4'b1000, '0, 32'd1, 5'd31, 1'b0);
        cchk("lui", 4'b1110, '0, 32'h0000_1234, '0, 1'b0);
        cchk("mem", 4'b1010, 32'h1001_0000, 32'd8, '0, 1'b0);
        cchk("mem_wrap", 4'b1010, '0, '0, '0, 1'b0);
        cchk("srl", 4'b1001, '0, 32'h8000_0000, 5'd4, 1'b0);
        cchk("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, '0, 1'b0);
        cchk("or", 4'b0001, 32'hF000_0001, 32'h000F_0010, '0, 1'b0);
        cchk("nor", 4'b0010, 32'hFFFF_0000, 32'h0000_FFFF, '0, 1'b0);
        cchk("sub", 4'b0100, 32'd3, 32'd5, '0, 1'b0);
        cchk("beq_eq", 4'b1100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, '0, 1'b0);
        cchk("jr", 4'b1011, 32'h0040_0020, '0, '0, 1'b0);
        cchk("unused", 4'b1111, 32'h1, 32'h2, '0, 1'b0);
        cchk("mult_idle", 4'b0101, 32'h1, 32'h2, '0, 1'b0);

        muldiv("mult_ff_2", 1'b0, 32'hFFFF_FFFF, 32'd2);
        muldiv("div_100_7", 1'b1, 32'd100, 32'd7);
        muldiv("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7);
        muldiv("div_5_0", 1'b1, 32'd5, 32'd0);
        muldiv("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        muldiv("mult_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        muldiv("mult_0", 1'b0, 32'h1234_5678, 32'd0);
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] b;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            muldiv($sformatf("rnd%0d", i), 1'($urandom), $urandom, b);
        end

        launch(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) rand_comb();
        reset = 1'b1;
        le_q.delete();
        m_hi = '0;
        m_lo = '0;
        cchk("rst_mid_mflo", 4'b1101, '0, '0, '0, 1'b0);
        cchk("rst_mid_mfhi", 4'b0111, '0, '0, '0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < W + 4; i++) cchk("post_rst_add", 4'b0011, $urandom, $urandom, '0, 1'b0);

        s_op = 4'b0101; s_a = 16'h00FF; s_b = 16'h0101; s_start = 1'b1;
        step();
        s_start = 1'b0;
        n = 1;
        while (!s_done && n < 60) begin
            step();
            n++;
        end
        chk("w16_latency", W'(n), W'(17));
        s_op = 4'b1101;
        #1 chk("w16_mflo", W'(s_res), W'(16'hFFFF));
        s_op = 4'b0111;
        #1 chk("w16_mfhi", W'(s_res), '0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
